// File: rtl/mips_pkg.sv
// Shared opcode constants, FSM encoding and access-decode helpers for the MIPS memory stage.
package mips_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_NONE = 2'd3
    } size_t;

    function automatic size_t accessSize(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: accessSize = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: accessSize = SIZE_HALF;
            OP_LW, OP_SW:         accessSize = SIZE_WORD;
            default:              accessSize = SIZE_NONE;
        endcase
    endfunction

    function automatic logic isStore(input logic [5:0] op);
        isStore = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic isMisaligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SIZE_HALF: isMisaligned = lo[0];
            SIZE_WORD: isMisaligned = (lo != 2'b00);
            default:   isMisaligned = 1'b0;
        endcase
    endfunction

    // Little-endian lanes: byte address offset N maps to MemBe[N].
    function automatic logic [3:0] byteEnable(input size_t sz, input logic [1:0] lo);
        case (sz)
            SIZE_BYTE: byteEnable = 4'b0001 << lo;
            SIZE_HALF: byteEnable = lo[1] ? 4'b1100 : 4'b0011;
            default:   byteEnable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] storeData(input size_t sz, input logic [31:0] d);
        case (sz)
            SIZE_BYTE: storeData = {4{d[7:0]}};
            SIZE_HALF: storeData = {2{d[15:0]}};
            default:   storeData = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory stage (master) and the memory system (slave).
interface mem_access_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBe;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;
    logic        MemAck;

    modport master (
        output MemReq, MemWe, MemAddr, MemBe, MemWdata,
        input  MemRdata, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemBe, MemWdata,
        output MemRdata, MemAck
    );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or zero-extends it.
module mem_load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  lane_i,
    input  logic [5:0]  opcode_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = rdata_i[{lane_i, 3'b000} +: 8];
        halfSel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (opcode_i)
            OP_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            OP_LBU:  data_o = {24'h0, byteSel};
            OP_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            OP_LHU:  data_o = {16'h0, halfSel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: decodes loads/stores from EX, runs one bus transaction
// with an ack timeout, and hands aligned results to writeback.
module mem_access
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [31:0]  Ins,
    input  logic [31:0]  Result,
    input  logic [31:0]  Rdata2,
    input  logic         InValid,
    mem_access_if.master bus,
    output logic [31:0]  Wdata,
    output logic [31:0]  InsOut,
    output logic         OutValid,
    output logic         Stall,
    output logic         Misalign,
    output logic         BusErr
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] busWdata_q, busWdata_d;
    logic        we_q, we_d;
    logic [31:0] reqIns_q, reqIns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] insOut_q, insOut_d;
    logic        outValid_q, outValid_d;
    logic        misalign_q, misalign_d;
    logic        busErr_q, busErr_d;
    logic [31:0] loadData;
    size_t       inSize;

    mem_load_align uAlign (
        .rdata_i  (bus.MemRdata),
        .lane_i   (lane_q),
        .opcode_i (reqIns_q[31:26]),
        .data_o   (loadData)
    );

    assign inSize = accessSize(Ins[31:26]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            waitCnt_q  <= '0;
            addr_q     <= '0;
            lane_q     <= '0;
            be_q       <= '0;
            busWdata_q <= '0;
            we_q       <= 1'b0;
            reqIns_q   <= '0;
            wdata_q    <= '0;
            insOut_q   <= '0;
            outValid_q <= 1'b0;
            misalign_q <= 1'b0;
            busErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            addr_q     <= addr_d;
            lane_q     <= lane_d;
            be_q       <= be_d;
            busWdata_q <= busWdata_d;
            we_q       <= we_d;
            reqIns_q   <= reqIns_d;
            wdata_q    <= wdata_d;
            insOut_q   <= insOut_d;
            outValid_q <= outValid_d;
            misalign_q <= misalign_d;
            busErr_q   <= busErr_d;
        end
    end

    // Result pulses default low each cycle; Wdata/InsOut hold until the next completion.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        be_d       = be_q;
        busWdata_d = busWdata_q;
        we_d       = we_q;
        reqIns_d   = reqIns_q;
        wdata_d    = wdata_q;
        insOut_d   = insOut_q;
        outValid_d = 1'b0;
        misalign_d = 1'b0;
        busErr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (inSize == SIZE_NONE) begin
                        outValid_d = 1'b1;
                        wdata_d    = Result;
                        insOut_d   = Ins;
                    end else if (isMisaligned(inSize, Result[1:0])) begin
                        outValid_d = 1'b1;
                        misalign_d = 1'b1;
                        wdata_d    = '0;
                        insOut_d   = Ins;
                    end else begin
                        state_d    = REQ;
                        waitCnt_d  = '0;
                        addr_d     = {Result[31:2], 2'b00};
                        lane_d     = Result[1:0];
                        be_d       = byteEnable(inSize, Result[1:0]);
                        busWdata_d = storeData(inSize, Rdata2);
                        we_d       = isStore(Ins[31:26]);
                        reqIns_d   = Ins;
                    end
                end
            end
            REQ: begin
                // An ack on the final allowed cycle still completes normally.
                if (bus.MemAck) begin
                    state_d    = IDLE;
                    outValid_d = 1'b1;
                    insOut_d   = reqIns_q;
                    wdata_d    = we_q ? '0 : loadData;
                end else if (waitCnt_q == LAST_WAIT) begin
                    state_d    = IDLE;
                    outValid_d = 1'b1;
                    busErr_d   = 1'b1;
                    insOut_d   = reqIns_q;
                    wdata_d    = '0;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Stall        = (state_q != IDLE);
    assign bus.MemReq   = (state_q == REQ);
    assign bus.MemWe    = (state_q == REQ) && we_q;
    assign bus.MemAddr  = addr_q;
    assign bus.MemBe    = be_q;
    assign bus.MemWdata = busWdata_q;
    assign Wdata        = wdata_q;
    assign InsOut       = insOut_q;
    assign OutValid     = outValid_q;
    assign Misalign     = misalign_q;
    assign BusErr       = busErr_q;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, legal 2..255: bus-ack timeout in cycles.
REQ-002 SHALL have ports: CLK in 1 clock; RST in 1 reset. One clock; reset is asynchronous and active-low.
REQ-003 SHALL have inputs Ins 32 (instruction from EX), Result 32 (EX ALU result/address), Rdata2 32 (store data), InValid 1 (EX output valid).
REQ-004 SHALL have data-bus ports: MemReq out 1, MemWe out 1, MemAddr out 32, MemBe out 4, MemWdata out 32, MemRdata in 32, MemAck in 1.
REQ-005 SHALL have outputs to WB: Wdata 32, InsOut 32, OutValid 1, Stall 1 (to EX/ID), Misalign 1, BusErr 1.

Function
REQ-006 SHALL decode Ins[31:26]: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; all other opcodes are non-memory.
REQ-007 SHALL use FSM states IDLE, REQ. Stall = (state != IDLE), combinational.
REQ-008 SHALL accept an instruction only when InValid=1 in IDLE; InValid while Stall=1 is ignored, and upstream holds its inputs.
REQ-009 Non-memory op accepted: next cycle OutValid=1, Wdata=Result, InsOut=Ins; state stays IDLE; throughput 1/cycle.
REQ-010 Aligned memory op accepted: register address, byte enables, store data and Ins, then go to REQ.
REQ-011 In REQ: MemReq=1; MemWe=1 for stores; all bus outputs stable until MemAck is sampled high.
REQ-012 MemAddr SHALL be {Result[31:2],2'b00}; lanes little-endian.
REQ-013 Byte ops: MemBe = one-hot bit Result[1:0]. Halfword ops: MemBe = 0011 if Result[1]=0, else 1100. Word ops: MemBe = 1111.
REQ-014 Store data: SB replicates Rdata2[7:0] ×4; SH replicates Rdata2[15:0] ×2; SW passes Rdata2.
REQ-015 MemAck=1 sampled in REQ: go to IDLE; next cycle OutValid=1.
REQ-016 Load result: Wdata = selected lane; LB/LH sign-extended, LBU/LHU zero-extended. Store result: Wdata = 0.
REQ-017 Zero-wait latency SHALL be 2 cycles from accept edge to OutValid; each wait cycle adds one.
REQ-018 Misaligned access (halfword with Result[0]=1; word with Result[1:0]!=0) SHALL NOT raise MemReq; next cycle OutValid=1, Misalign=1, Wdata=0; state stays IDLE.
REQ-019 If MemAck is not sampled within MAX_WAIT cycles of MemReq high: drop MemReq, go to IDLE; next cycle OutValid=1, BusErr=1, Wdata=0.
REQ-020 MemAck outside REQ SHALL be ignored.
REQ-021 OutValid, Misalign and BusErr SHALL be single-cycle pulses; Wdata and InsOut hold until the next OutValid.

Reset
REQ-022 RST=0 SHALL immediately force state IDLE, wait counter 0, and all outputs 0 (Stall=0, MemReq=0).
REQ-023 Reset during REQ SHALL abandon the transaction with no OutValid; a MemAck arriving after reset release SHALL be ignored.

Structure
REQ-024 Opcode constants and the FSM state encoding SHALL live in shared package mips_pkg.
REQ-025 Lane extraction and sign/zero extension SHALL be one combinational sub-module, mem_load_align.
REQ-026 The wait counter SHALL be 8 bits, reset on entry to REQ.

Verification
REQ-027 LW: Ins=8C000004, Result=00001004, MemAck on 2nd REQ cycle, MemRdata=DEADBEEF -> MemAddr=00001004, MemBe=1111, Stall high 2 cycles, Wdata=DEADBEEF, OutValid on 3rd cycle after accept.
REQ-028 LB/LBU: Ins=80000000 or 90000000, Result=00001003, MemRdata=80FF0000, zero-wait ack -> MemBe=1000; Wdata=FFFFFF80 (LB) and 00000080 (LBU).
REQ-029 SH: Ins=A4000000, Result=00002002, Rdata2=12345678 -> MemWe=1, MemAddr=00002000, MemBe=1100, MemWdata=56785678, Wdata=0.
REQ-030 Misaligned LW: Result=00001001 -> MemReq never high; OutValid and Misalign pulse 1 cycle after accept.
REQ-031 Timeout: MAX_WAIT=16, MemAck held 0 -> MemReq high exactly 16 cycles, then BusErr and OutValid pulse; a late MemAck is ignored.
REQ-032 Back-to-back ADD (Ins=00000020): Result 8 then 9 -> Wdata 8 then 9 on consecutive cycles, Stall=0. RST=0 asserted mid-REQ -> MemReq=0 immediately and no OutValid.
